// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache miss block-fill sequencer and memory4c port arbiter
//            for write-through stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           store_req,
  input  logic [ADDR_W-1:0]              store_addr,
  input  logic [15:0]                    store_data,
  output logic                           fsm_busy,
  output logic                           store_ack,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           memory_enable,
  output logic                           memory_wr,
  output logic [15:0]                    memory_data_in,
  input  logic [15:0]                    memory_data,
  input  logic                           memory_data_valid
);

  localparam int c_IDX_W = $clog2(BLOCK_WORDS);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam int c_OFF_W = c_IDX_W + 1;  // byte offset bits: two bytes per word

  localparam logic [ADDR_W-1:0]  c_OFF_MASK = ADDR_W'((1 << c_OFF_W) - 1);
  localparam logic [c_CNT_W-1:0] c_WORDS    = c_CNT_W'(BLOCK_WORDS);
  localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_issue_cnt;
  logic [c_CNT_W-1:0]   w_issue_cnt_nxt;
  logic [c_IDX_W-1:0]   r_recv_cnt;
  logic [c_IDX_W-1:0]   w_recv_cnt_nxt;
  logic [ADDR_W-1:0]    r_base;
  logic [ADDR_W-1:0]    w_base_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_recv_cnt  <= w_recv_cnt_nxt;
      r_base      <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_issue_cnt_nxt  = r_issue_cnt;
    w_recv_cnt_nxt   = r_recv_cnt;
    w_base_nxt       = r_base;
    fsm_busy         = 1'b0;
    store_ack        = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    memory_address   = '0;
    memory_enable    = 1'b0;
    memory_wr        = 1'b0;
    memory_data_in   = '0;

    case (r_state)
      S_IDLE: begin
        // A miss wins over a simultaneous store; the store remains pending.
        if (miss_detected) begin
          w_base_nxt      = miss_address & ~c_OFF_MASK;
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          w_state_nxt     = S_FILL;
        end else if (store_req) begin
          w_state_nxt = S_STORE;
        end
      end

      S_FILL: begin
        fsm_busy = 1'b1;
        if (r_issue_cnt < c_WORDS) begin
          memory_enable   = 1'b1;
          memory_address  = r_base + ADDR_W'({r_issue_cnt, 1'b0});
          w_issue_cnt_nxt = r_issue_cnt + 1'b1;
        end
        // Completion tracks returned words only, independent of latency.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = r_recv_cnt;
          fill_data        = memory_data;
          w_recv_cnt_nxt   = r_recv_cnt + 1'b1;
          if (r_recv_cnt == c_LAST) begin
            write_tag_array = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end
      end

      S_STORE: begin
        memory_enable  = 1'b1;
        memory_wr      = 1'b1;
        memory_address = store_addr;
        memory_data_in = store_data;
        store_ack      = 1'b1;
        w_state_nxt    = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Randomized self-checking bench for cache_fill_fsm against a
//            cycle-schedule reference derived from fill/store timing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        store_req;
  logic [15:0] store_addr;
  logic [15:0] store_data;
  logic        fsm_busy;
  logic        store_ack;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic [15:0] memory_address;
  logic        memory_enable;
  logic        memory_wr;
  logic [15:0] memory_data_in;
  logic [15:0] memory_data;
  logic        memory_data_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cur_lat  = 1;
  int wr_count = 0;
  bit stray_en = 1'b0;

  // Pending memory reads: cycle in which each word returns, and its data.
  int          q_due[$];
  logic [15:0] q_dat[$];

  cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .store_req        (store_req),
    .store_addr       (store_addr),
    .store_data       (store_data),
    .fsm_busy         (fsm_busy),
    .store_ack        (store_ack),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .fill_word        (fill_word),
    .fill_data        (fill_data),
    .memory_address   (memory_address),
    .memory_enable    (memory_enable),
    .memory_wr        (memory_wr),
    .memory_data_in   (memory_data_in),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return ({a[7:0], a[15:8]} ^ 16'h5A3C) + a;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: memory responds, outputs are compared at the falling edge.
  task automatic tick(input bit e_busy, input bit e_en, input bit e_wr,
                      input logic [15:0] e_addr, input logic [15:0] e_din,
                      input bit e_ack, input bit e_wda, input bit e_wta,
                      input logic [2:0] e_fw, input logic [15:0] e_fd);
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = q_dat[0];
      void'(q_due.pop_front());
      void'(q_dat.pop_front());
    end else begin
      memory_data_valid = stray_en && ($urandom_range(0, 1) == 1);
      memory_data       = 16'($urandom);
    end
    @(negedge clk);
    check("fsm_busy", 16'(fsm_busy), 16'(e_busy));
    check("memory_enable", 16'(memory_enable), 16'(e_en));
    check("memory_wr", 16'(memory_wr), 16'(e_wr));
    if (e_en || rst) check("memory_address", memory_address, e_addr);
    check("memory_data_in", memory_data_in, e_din);
    check("store_ack", 16'(store_ack), 16'(e_ack));
    check("write_data_array", 16'(write_data_array), 16'(e_wda));
    check("write_tag_array", 16'(write_tag_array), 16'(e_wta));
    check("fill_word", 16'(fill_word), 16'(e_fw));
    check("fill_data", fill_data, e_fd);
    if (write_data_array) wr_count++;
    if (memory_enable && !memory_wr) begin
      q_due.push_back(cyc + cur_lat);
      q_dat.push_back(mem_word(memory_address));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 16'h0);
  endtask

  // Cycle k (1-based) after a miss was sampled, for a block at base with latency lat.
  task automatic fill_cycle(input logic [15:0] base, input int lat, input int k);
    bit en;
    bit wd;
    int w;
    en = (k <= 8);
    wd = (k > lat) && (k <= 8 + lat);
    w  = k - 1 - lat;
    tick(1, en, 0, en ? 16'(base + 2 * (k - 1)) : 16'h0, 16'h0, 0,
         wd, (k == 8 + lat), wd ? 3'(w) : 3'd0,
         wd ? mem_word(16'(base + 2 * w)) : 16'h0);
  endtask

  task automatic run_fill(input logic [15:0] addr, input int lat, input bit with_store,
                          input logic [15:0] saddr, input logic [15:0] sdata,
                          input bit extra_miss);
    logic [15:0] base;
    base          = addr & 16'hFFF0;
    cur_lat       = lat;
    wr_count      = 0;
    stray_en      = 1'b1;
    miss_detected = 1'b1;
    miss_address  = addr;
    store_req     = with_store;
    store_addr    = saddr;
    store_data    = sdata;
    idle_tick();
    stray_en = 1'b0;
    for (int k = 1; k <= 8 + lat; k++) begin
      miss_detected = extra_miss && (k == 3 || k == 8 + lat);
      miss_address  = 16'($urandom);
      fill_cycle(base, lat, k);
    end
    check("words_per_fill", 16'(wr_count), 16'd8);
    miss_detected = 1'b0;
    stray_en      = 1'b1;
    idle_tick();
    if (with_store) begin
      tick(0, 1, 1, saddr, sdata, 1, 0, 0, 3'd0, 16'h0);
      store_req = 1'b0;
    end
  endtask

  // n stores presented back to back; requester holds each until acknowledged.
  task automatic run_stores(input int n);
    logic [15:0] sa;
    logic [15:0] sd;
    stray_en      = 1'b1;
    miss_detected = 1'b0;
    for (int i = 0; i < n; i++) begin
      sa         = 16'($urandom);
      sd         = 16'($urandom);
      store_req  = 1'b1;
      store_addr = sa;
      store_data = sd;
      idle_tick();
      tick(0, 1, 1, sa, sd, 1, 0, 0, 3'd0, 16'h0);
    end
    store_req = 1'b0;
    idle_tick();
  endtask

  task automatic reset_mid_fill(input logic [15:0] addr);
    logic [15:0] base;
    base          = addr & 16'hFFF0;
    cur_lat       = 4;
    stray_en      = 1'b0;
    miss_detected = 1'b1;
    miss_address  = addr;
    idle_tick();
    miss_detected = 1'b0;
    for (int k = 1; k <= 5; k++) fill_cycle(base, 4, k);
    rst = 1'b1;
    q_due.delete();
    q_dat.delete();
    idle_tick();
    stray_en      = 1'b1;
    miss_detected = 1'b1;
    idle_tick();
    rst           = 1'b0;
    miss_detected = 1'b0;
    idle_tick();
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    store_req         = 1'b0;
    store_addr        = 16'h0;
    store_data        = 16'h0;
    memory_data       = 16'h0;
    memory_data_valid = 1'b0;
    @(posedge clk);
    #1;
    stray_en = 1'b1;
    idle_tick();
    idle_tick();
    rst = 1'b0;
    idle_tick();

    run_fill(16'h1236, 4, 0, 16'h0, 16'h0, 0);
    store_req  = 1'b1;
    store_addr = 16'h0040;
    store_data = 16'hBEEF;
    idle_tick();
    tick(0, 1, 1, 16'h0040, 16'hBEEF, 1, 0, 0, 3'd0, 16'h0);
    store_req = 1'b0;
    idle_tick();
    run_fill(16'h2000, 4, 1, 16'h3000, 16'h1357, 0);
    reset_mid_fill(16'h4A5C);
    run_fill(16'h4A5C, 4, 0, 16'h0, 16'h0, 0);
    run_fill(16'h7FF2, 3, 0, 16'h0, 16'h0, 1);
    repeat (4) idle_tick();
    run_stores(3);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0)
        run_fill(16'($urandom), int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
      else
        run_stores(int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) idle_tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
